// File: rtl/line_iterator_if.sv
// Row-sequencer to line_buffer link: row index and compute flag out, valid_set back.
// No handshake; the row advances every clock once a generation is running.
interface line_iterator_if #(
    parameter int ROW_W = 10
);
    logic [ROW_W-1:0] calc_row;
    logic             calc_flag;
    logic             valid_set;

    modport master (output calc_row, output calc_flag, input valid_set);
    modport slave  (input calc_row, input calc_flag, output valid_set);
endinterface

// File: rtl/line_iterator.sv
// Frame row sequencer for line_buffer: PRIME / RUN / DRAIN per generation, optional gen_count via GEN_COUNTER_EN.
// Outputs registered, one row per clock; frame_tick while busy is dropped and flagged in overrun.
module line_iterator #(
    parameter int ROWS         = 720,
    parameter int ROW_W        = 10,
    parameter int PRIME_CYCLES = 3,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_tick_i,
    input  logic                   run_en_i,
    input  logic                   step_i,
    line_iterator_if.master        lb,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic                   bank_sel_o,
    output logic                   overrun_o,
`ifdef GEN_COUNTER_EN
    output logic [15:0]            gen_count_o,
`endif
    output logic                   sync_err_o
);
    typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [7:0]       PRIME_LAST = 8'(PRIME_CYCLES - 1);
    localparam logic [7:0]       DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             flag_q, flag_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bank_q, bank_d;
    logic             ovr_q, ovr_d;
    logic             serr_q, serr_d;
    logic             pend_q, pend_d;
    logic [15:0]      gen_q, gen_d;
    logic             start;

    assign start = (state_q == IDLE) && frame_tick_i && (run_en_i || step_i || pend_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        flag_d  = flag_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bank_d  = bank_q;
        ovr_d   = ovr_q;
        serr_d  = serr_q;
        gen_d   = gen_q;
        pend_d  = pend_q;

        if (start)
            pend_d = 1'b0;
        else if (step_i)
            pend_d = 1'b1;

        if (frame_tick_i && busy_q)
            ovr_d = 1'b1;

        case (state_q)
            IDLE: begin
                // Parking on the last row keeps line_buffer in cleanup so its fill counter is zero
                row_d  = ROW_LAST;
                flag_d = 1'b0;
                if (start) begin
                    state_d = PRIME;
                    row_d   = '0;
                    flag_d  = (PRIME_CYCLES == 1);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            PRIME: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == PRIME_LAST) begin
                    state_d = RUN;
                    row_d   = ROW_W'(1);
                    flag_d  = 1'b1;
                end else begin
                    flag_d  = (cnt_q == PRIME_LAST - 8'd1);
                end
            end
            RUN: begin
                if (!lb.valid_set)
                    serr_d = 1'b1;
                if (row_q == ROW_LAST) begin
                    state_d = DRAIN;
                    flag_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == DRAIN_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    bank_d  = ~bank_q;
                    busy_d  = 1'b0;
                    gen_d   = gen_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= ROW_LAST;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bank_q  <= 1'b0;
            ovr_q   <= 1'b0;
            serr_q  <= 1'b0;
            pend_q  <= 1'b0;
            gen_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            flag_q  <= flag_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bank_q  <= bank_d;
            ovr_q   <= ovr_d;
            serr_q  <= serr_d;
            pend_q  <= pend_d;
            gen_q   <= gen_d;
        end
    end

    assign lb.calc_row  = row_q;
    assign lb.calc_flag = flag_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign bank_sel_o   = bank_q;
    assign overrun_o    = ovr_q;
    assign sync_err_o   = serr_q;

`ifdef GEN_COUNTER_EN
    assign gen_count_o  = gen_q;
`else
    logic unused_gen;
    assign unused_gen = ^gen_q;
`endif
endmodule

// File: tb/tb_line_iterator.sv
// Scoreboard bench for line_iterator: stimulus queues the expected per-cycle row/flag stream and done events,
// a negedge monitor pops and compares whenever the DUT is busy or pulses frame_done.
module tb_line_iterator;
    localparam int ROWS    = 720;
    localparam int ROW_W   = 10;
    localparam int GEN_LEN = 724;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, frame_tick, run_en, step, vset;
    logic busy, frame_done, bank_sel, overrun, sync_err;
`ifdef GEN_COUNTER_EN
    logic [15:0] gen_count;
`endif

    line_iterator_if #(.ROW_W(ROW_W)) lb_if ();
    assign lb_if.valid_set = vset;

    line_iterator #(.ROWS(ROWS), .ROW_W(ROW_W), .PRIME_CYCLES(3), .DRAIN_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick_i (frame_tick),
        .run_en_i     (run_en),
        .step_i       (step),
        .lb           (lb_if),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .bank_sel_o   (bank_sel),
        .overrun_o    (overrun),
`ifdef GEN_COUNTER_EN
        .gen_count_o  (gen_count),
`endif
        .sync_err_o   (sync_err)
    );

    int errors = 0;
    int checks = 0;
    logic [10:0] exp_q[$];
    logic        exp_done_q[$];
    logic        exp_bank = 1'b0;
    int          gen_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    task automatic push_gen();
        exp_q.push_back({10'd0, 1'b0});
        exp_q.push_back({10'd0, 1'b0});
        exp_q.push_back({10'd0, 1'b1});
        for (int r = 1; r < ROWS; r++) exp_q.push_back({10'(r), 1'b1});
        exp_q.push_back({10'd719, 1'b0});
        exp_q.push_back({10'd719, 1'b0});
        exp_bank = ~exp_bank;
        exp_done_q.push_back(exp_bank);
        gen_cnt++;
    endtask

    // Monitor
    int   cyc = 0;
    int   start_cyc = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        logic [10:0] e;
        logic        b;
        cyc++;
        if (!rst) begin
            if (busy) begin
                if (!prev_busy) start_cyc = cyc;
                if (exp_q.size() == 0) fail("unexpected_busy");
                else begin
                    e = exp_q.pop_front();
                    chk("row_flag", {21'd0, lb_if.calc_row, lb_if.calc_flag}, {21'd0, e});
                end
            end else begin
                chk("idle_row_flag", {21'd0, lb_if.calc_row, lb_if.calc_flag}, {21'd0, 10'd719, 1'b0});
            end
            if (frame_done) begin
                if (exp_done_q.size() == 0) fail("extra_frame_done");
                else begin
                    b = exp_done_q.pop_front();
                    chk("bank_sel_at_done", 32'(bank_sel), 32'(b));
                    chk("gen_length", cyc - start_cyc, GEN_LEN);
                    chk("stream_drained", exp_q.size(), 0);
                end
            end
        end
        prev_busy = busy;
    end

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick(input bit expect_gen);
        frame_tick = 1'b1;
        if (expect_gen) push_gen();
        adv(1);
        frame_tick = 1'b0;
    endtask

    task automatic wait_row(input int r);
        int n = 0;
        while (!(lb_if.calc_row == 10'(r) && lb_if.calc_flag && busy) && n < 2000) begin
            adv(1);
            n++;
        end
        if (n >= 2000) fail("wait_row_timeout");
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            adv(1);
            n++;
        end
        if (n >= 2000) fail("wait_idle_timeout");
        adv(2);
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; run_en = 1'b0; step = 1'b0; vset = 1'b1;
        adv(3);
        rst = 1'b0;
        adv(1);
        chk("rst_calc_row", 32'(lb_if.calc_row), 719);
        chk("rst_calc_flag", 32'(lb_if.calc_flag), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_bank_sel", 32'(bank_sel), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_sync_err", 32'(sync_err), 0);

        // Free-run single generation
        run_en = 1'b1;
        tick(1);
        chk("busy_after_tick", 32'(busy), 1);
        wait_idle();
        chk("bank_after_gen1", 32'(bank_sel), 32'(exp_bank));
        chk("sync_err_clean", 32'(sync_err), 0);
        chk("overrun_clean", 32'(overrun), 0);

        // run_en dropped mid-frame: current gen completes, next tick ignored
        tick(1);
        wait_row(100);
        run_en = 1'b0;
        wait_idle();
        tick(0);
        adv(800);
        chk("no_gen_after_run_drop", 32'(busy), 0);

        // Single step: two ticks 2000 cycles apart, only one generation
        step = 1'b1;
        adv(1);
        step = 1'b0;
        adv(5);
        tick(1);
        adv(2000);
        tick(0);
        adv(800);
        chk("bank_after_step", 32'(bank_sel), 32'(exp_bank));
        chk("overrun_after_step", 32'(overrun), 0);

        // Tick during RUN sets sticky overrun, sequence undisturbed
        run_en = 1'b1;
        tick(1);
        wait_row(300);
        tick(0);
        adv(1);
        chk("overrun_set", 32'(overrun), 1);
        wait_idle();
        chk("overrun_sticky", 32'(overrun), 1);

        // valid_set low for one RUN cycle
        tick(1);
        wait_row(10);
        vset = 1'b0;
        adv(1);
        vset = 1'b1;
        adv(2);
        chk("sync_err_set", 32'(sync_err), 1);
        wait_idle();
        chk("sync_err_sticky", 32'(sync_err), 1);

        // Reset mid-RUN aborts to reset values
        tick(1);
        wait_row(500);
        rst = 1'b1;
        adv(1);
        exp_q.delete();
        exp_done_q.delete();
        exp_bank = 1'b0;
        gen_cnt  = 0;
        chk("midrst_calc_row", 32'(lb_if.calc_row), 719);
        chk("midrst_calc_flag", 32'(lb_if.calc_flag), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_bank_sel", 32'(bank_sel), 0);
        chk("midrst_overrun", 32'(overrun), 0);
        chk("midrst_sync_err", 32'(sync_err), 0);
        rst = 1'b0;
        adv(2);

        // Clean restart plus two more generations
        for (int g = 0; g < 3; g++) begin
            tick(1);
            wait_idle();
        end
        chk("bank_after_3gen", 32'(bank_sel), 32'(exp_bank));
        chk("sync_err_after_restart", 32'(sync_err), 0);
`ifdef GEN_COUNTER_EN
        chk("gen_count", 32'(gen_count), 32'(gen_cnt));
`endif
        chk("exp_done_empty", exp_done_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
